// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage, pointers, occupancy counter, registered status flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_ctrl #(
  parameter int ADDR_LEN  = 8,
  parameter int DATA_LEN  = 32,
  parameter int AFULL_TH  = 252,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic                ren_i,
  output logic [DATA_LEN-1:0] rdata_o,
  output logic                rvalid_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic [ADDR_LEN:0]   count_o,
  input  logic                err_clr_i,
  output logic                ovf_o,
  output logic                udf_o
);

  localparam int                DEPTH      = 1 << ADDR_LEN;
  localparam logic [ADDR_LEN:0] ONE        = (ADDR_LEN+1)'(1);
  localparam logic [ADDR_LEN:0] DEPTH_CNT  = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0] AFULL_CNT  = (ADDR_LEN+1)'(AFULL_TH);
  localparam logic [ADDR_LEN:0] AEMPTY_CNT = (ADDR_LEN+1)'(AEMPTY_TH);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [ADDR_LEN:0]   wptr;
  logic [ADDR_LEN:0]   rptr;
  logic [ADDR_LEN:0]   count_next;
  logic                wr_acc;
  logic                rd_acc;

  // Accept decisions use the registered flags, so nothing combinational reaches an output.
  assign wr_acc = wen_i && !full_o;
  assign rd_acc = ren_i && !empty_o;

  // NOTE: every path assigns count_next (default arm), so no latch is inferred.
  always_comb begin
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_o + ONE;
      2'b01:   count_next = count_o - ONE;
      default: count_next = count_o;
    endcase
  end

  // NOTE: storage is deliberately not reset; reset only clears pointers, so stale words are unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr[ADDR_LEN-1:0]] <= wdata_i;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr           <= '0;
      rptr           <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      rdata_o        <= '0;
      rvalid_o       <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) begin
        rptr    <= rptr + ONE;
        rdata_o <= mem[rptr[ADDR_LEN-1:0]];
      end
      rvalid_o       <= rd_acc;
      count_o        <= count_next;
      // Flags follow next-state count so they stay coherent with count_o.
      full_o         <= (count_next == DEPTH_CNT);
      empty_o        <= (count_next == '0);
      almost_full_o  <= (count_next >= AFULL_CNT);
      almost_empty_o <= (count_next <= AEMPTY_CNT);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (wen_i && full_o)  ovf_o <= 1'b1;
      else if (err_clr_i)   ovf_o <= 1'b0;
      if (ren_i && empty_o) udf_o <= 1'b1;
      else if (err_clr_i)   udf_o <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign ovf_o          = 1'b0;
  assign udf_o          = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_sync_fifo_ctrl;

  localparam int ADDR_LEN  = 3;
  localparam int DATA_LEN  = 16;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 2;
  localparam int DEPTH     = 8;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                wen_i;
  logic [DATA_LEN-1:0] wdata_i;
  logic                ren_i;
  logic [DATA_LEN-1:0] rdata_o;
  logic                rvalid_o;
  logic                full_o;
  logic                empty_o;
  logic                almost_full_o;
  logic                almost_empty_o;
  logic [ADDR_LEN:0]   count_o;
  logic                err_clr_i;
  logic                ovf_o;
  logic                udf_o;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  sync_fifo_ctrl #(
    .ADDR_LEN (ADDR_LEN),
    .DATA_LEN (DATA_LEN),
    .AFULL_TH (AFULL_TH),
    .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wen_i         (wen_i),
    .wdata_i       (wdata_i),
    .ren_i         (ren_i),
    .rdata_o       (rdata_o),
    .rvalid_o      (rvalid_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .count_o       (count_o),
    .err_clr_i     (err_clr_i),
    .ovf_o         (ovf_o),
    .udf_o         (udf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, read port and sticky flags as plain variables.
  logic [DATA_LEN-1:0] q[$];
  logic [DATA_LEN-1:0] m_rdata;
  bit                  m_rvalid;
  bit                  m_ovf;
  bit                  m_udf;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (wen_i && was_full) m_ovf = 1'b1;
      else if (err_clr_i)    m_ovf = 1'b0;
      if (ren_i && was_empty) m_udf = 1'b1;
      else if (err_clr_i)     m_udf = 1'b0;
      m_rvalid = ren_i && !was_empty;
      if (m_rvalid) m_rdata = q.pop_front();
      if (wen_i && !was_full) q.push_back(wdata_i);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("count",        32'(count_o),     32'(q.size()));
      check("full",         32'(full_o),      32'(q.size() == DEPTH));
      check("empty",        32'(empty_o),     32'(q.size() == 0));
      check("almost_full",  32'(almost_full_o),  32'(q.size() >= AFULL_TH));
      check("almost_empty", 32'(almost_empty_o), 32'(q.size() <= AEMPTY_TH));
      check("rvalid",       32'(rvalid_o),    32'(m_rvalid));
      check("rdata",        32'(rdata_o),     32'(m_rdata));
      check("ovf",          32'(ovf_o),       32'(ERR_EN && m_ovf));
      check("udf",          32'(udf_o),       32'(ERR_EN && m_udf));
    end
  end

  // Applies one cycle of inputs at a falling edge and returns at the next falling edge.
  task automatic cycle(input bit w, input logic [DATA_LEN-1:0] d, input bit r, input bit c);
    wen_i     = w;
    wdata_i   = d;
    ren_i     = r;
    err_clr_i = c;
    @(negedge clk);
  endtask

  initial begin
    int wp, rp;
    rst = 1'b1; wen_i = 1'b0; wdata_i = '0; ren_i = 1'b0; err_clr_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;

    // 1. Reset state
    check("rst_count",  32'(count_o), 0);
    check("rst_empty",  32'(empty_o), 1);
    check("rst_aempty", 32'(almost_empty_o), 1);
    check("rst_full",   32'(full_o), 0);
    check("rst_rvalid", 32'(rvalid_o), 0);
    check("rst_rdata",  32'(rdata_o), 0);
    rst = 1'b0;
    cycle(0, '0, 0, 0);

    // 2. Fill to full, then overflow attempt
    for (int i = 1; i <= 8; i++) begin
      cycle(1, DATA_LEN'(i), 0, 0);
      if (i == 2) check("aempty_after_2", 32'(almost_empty_o), 1);
      if (i == 3) check("aempty_after_3", 32'(almost_empty_o), 0);
      if (i == 5) check("afull_after_5",  32'(almost_full_o), 0);
      if (i == 6) check("afull_after_6",  32'(almost_full_o), 1);
    end
    check("full_after_8",  32'(full_o), 1);
    check("count_after_8", 32'(count_o), 8);
    cycle(1, 16'h00FF, 0, 0);
    check("count_after_ovf", 32'(count_o), 8);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_set", 32'(ovf_o), 1);
`endif

    // 3. Drain in order, then underflow attempt
    for (int i = 1; i <= 8; i++) begin
      cycle(0, '0, 1, 0);
      check("drain_rdata",  32'(rdata_o), i);
      check("drain_rvalid", 32'(rvalid_o), 1);
    end
    cycle(0, '0, 0, 0);
    check("empty_after_drain", 32'(empty_o), 1);
    cycle(0, '0, 1, 0);
    check("udf_rvalid", 32'(rvalid_o), 0);
    check("udf_rdata_hold", 32'(rdata_o), 16'h0008);
`ifdef SYNC_FIFO_ERR_EN
    check("udf_set", 32'(udf_o), 1);
`endif
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);

    // 4. Wrap-around with single write then read
    for (int n = 0; n < 20; n++) begin
      cycle(1, DATA_LEN'(16'h0100 + n), 0, 0);
      check("wrap_count1", 32'(count_o), 1);
      cycle(0, '0, 1, 0);
      check("wrap_rdata", 32'(rdata_o), 32'h0100 + n);
      check("wrap_count0", 32'(count_o), 0);
    end

    // 5. Simultaneous traffic with 4 stored, then on empty
    for (int k = 0; k < 4; k++) cycle(1, DATA_LEN'(16'h0200 + k), 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, DATA_LEN'(16'h0300 + k), 1, 0);
      check("simul_count", 32'(count_o), 4);
      check("simul_rdata", 32'(rdata_o), (k < 4) ? 32'h0200 + k : 32'h0300);
    end
    for (int k = 0; k < 4; k++) cycle(0, '0, 1, 0);
    check("simul_drain_last", 32'(rdata_o), 32'h0304);
    cycle(0, '0, 0, 0);
    cycle(1, 16'hBEEF, 1, 0);
    check("empty_rw_rvalid", 32'(rvalid_o), 0);
    check("empty_rw_count",  32'(count_o), 1);
    cycle(0, '0, 1, 0);
    check("empty_rw_rdata", 32'(rdata_o), 32'hBEEF);

    // 6. Reset mid-operation
    for (int k = 0; k < 5; k++) cycle(1, DATA_LEN'(16'h0400 + k), 0, 0);
    rst = 1'b1;
    cycle(0, '0, 1, 0);
    rst = 1'b0;
    check("midrst_count",  32'(count_o), 0);
    check("midrst_empty",  32'(empty_o), 1);
    check("midrst_rvalid", 32'(rvalid_o), 0);
    cycle(1, 16'hABCD, 0, 0);
    cycle(0, '0, 1, 0);
    check("midrst_rdata", 32'(rdata_o), 32'hABCD);

    // Randomized traffic, biased alternately toward filling and draining
    for (int t = 0; t < 600; t++) begin
      wp = ((t / 40) % 2 == 0) ? 80 : 25;
      rp = 100 - wp;
      rst = ($urandom_range(0, 99) == 0);
      cycle($urandom_range(0, 99) < wp, DATA_LEN'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 15) == 0);
    end
    rst = 1'b0;
    cycle(0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
